asm_deint_ctrl: RTL and testbench
=================================

ASM_DEINT_CTRL -- requirements
Module: asm_deint_ctrl

Interface
REQ-001 Parameter NCOL, default 8: interleaver column count; all supported frame lengths are multiples of NCOL.
REQ-002 Parameter ADDRESS, default 16: RAM address width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din_vld  input  1  one interleaved sample arriving this cycle.
REQ-006 m_len  input  13  frame length in samples, sampled on the first din_vld of a frame.
REQ-007 request  input  1  downstream pull of one deinterleaved sample.
REQ-008 wen  output  1  RAM write strobe.
REQ-009 waddr  output  ADDRESS  RAM write address.
REQ-010 ren  output  1  RAM read strobe.
REQ-011 raddr  output  ADDRESS  RAM read address.
REQ-012 dout_vld  output  1  RAM read data valid, aligned with RAM output.
REQ-013 frame_done  output  1  one-cycle pulse when the last sample of a frame is read.
REQ-014 err  output  1  sticky error flag, cleared only by rst.

Function
REQ-015 States IDLE, WRITE, READ; IDLE->WRITE on din_vld with a supported m_len; WRITE->READ when the m_len-th sample is written; READ->IDLE when the m_len-th ren issues.
REQ-016 Supported m_len and base offset: 952->0x0000, 288->0x03C0, 672->0x04E0, 1056->0x0780; base and nrow=m_len>>3 are latched on the entering din_vld and held for the frame.
REQ-017 Write side: wen = din_vld while in IDLE (entering) or WRITE, combinational, same cycle as din_vld.
REQ-018 Write counters row (0..nrow-1) and col (0..NCOL-1) start at 0; each write increments row; on row wrap to 0, col increments.
REQ-019 waddr = base + row*NCOL + col, computed as shift-and-add, modulo 2^ADDRESS.
REQ-020 Read side: in READ, ren = request combinational; raddr = base + rcnt; rcnt starts at 0, increments per ren.
REQ-021 dout_vld = ren registered, latency exactly 1 cycle; frame_done = registered (ren and rcnt==m_len-1), coincident with the final dout_vld.
REQ-022 din_vld in READ: no write, counters unaffected.
REQ-023 request in IDLE or WRITE: no ren, ignored.
REQ-024 din_vld in the same cycle as the final ren: ignored; the next frame starts on a later din_vld in IDLE.
REQ-025 din_vld gaps in WRITE and request gaps in READ stall counters without error.
REQ-026 Unsupported m_len on the entering din_vld: remain in IDLE, no wen.

Reset
REQ-027 rst forces state IDLE, all counters, base, nrow to 0; wen, ren, dout_vld, frame_done, err to 0; waddr and raddr read 0.
REQ-028 rst mid-frame abandons the frame; the next din_vld after release starts a fresh frame.

Configuration
REQ-029 Macro ASM_DEINT_ERR_EN defined: err sets on unsupported m_len in IDLE or on din_vld in READ.
REQ-030 Macro ASM_DEINT_ERR_EN undefined: err is constant 0 and no error logic is built; REQ-026 and REQ-022 behaviour is unchanged.

Verification
REQ-031 m_len=288, 288 continuous din_vld -> waddrs 0x03C0,0x03C8,...,0x03C0+35*8, then 0x03C1,...; last waddr 0x03C0+287; state READ afterward.
REQ-032 After REQ-031, 288 continuous request -> raddr 0x03C0..0x04DF, dout_vld one cycle after each ren, frame_done with the 288th dout_vld, state IDLE.
REQ-033 m_len=952 with din_vld every other cycle and request 1-in-3 -> same address sequences as continuous, with no lost or duplicated addresses.
REQ-034 m_len=500 with din_vld -> no wen, stays IDLE; err=1 with ASM_DEINT_ERR_EN, err=0 without.
REQ-035 m_len=1056, rst asserted after 100 writes -> all outputs 0 next cycle; new frame m_len=672 then starts with waddr 0x04E0.
REQ-036 din_vld pulsed during READ of m_len=672 -> no wen, read sequence unchanged; err=1 with ASM_DEINT_ERR_EN.

Source files
------------

// File: rtl/asm_deint_ctrl.sv
// asm_deint_ctrl: address/strobe controller for a block deinterleaver RAM.
// Samples are written column-wise (row-major waddr stepping by NCOL) and read
// back linearly. Optional sticky error flag built only when ASM_DEINT_ERR_EN
// is defined; otherwise err is tied low.
module asm_deint_ctrl #(
  parameter int NCOL    = 8,
  parameter int ADDRESS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_vld,
  input  logic [12:0]        m_len,
  input  logic               request,
  output logic               wen,
  output logic [ADDRESS-1:0] waddr,
  output logic               ren,
  output logic [ADDRESS-1:0] raddr,
  output logic               dout_vld,
  output logic               frame_done,
  output logic               err
);

  localparam int SH = $clog2(NCOL);
  localparam int CW = (SH > 0) ? SH : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t             state;
  logic [ADDRESS-1:0] base;
  logic [12:0]        nrow;
  logic [12:0]        row;
  logic [CW-1:0]      col;
  logic [12:0]        rcnt;

  logic               lut_ok;
  logic [ADDRESS-1:0] lut_base;
  logic               entering;
  logic [ADDRESS-1:0] wr_base;
  logic [12:0]        flen;
  logic               row_last;
  logic               wr_last;
  logic               rd_last;

  // Supported frame lengths and their RAM base offsets
  always_comb begin
    lut_ok   = 1'b1;
    lut_base = '0;
    case (m_len)
      13'd952:  lut_base = ADDRESS'(16'h0000);
      13'd288:  lut_base = ADDRESS'(16'h03C0);
      13'd672:  lut_base = ADDRESS'(16'h04E0);
      13'd1056: lut_base = ADDRESS'(16'h0780);
      default:  lut_ok   = 1'b0;
    endcase
  end

  // Strobes and addresses; the entering write uses the not-yet-latched base
  always_comb begin
    entering = (state == IDLE) && din_vld && lut_ok && !rst;
    wen      = entering || ((state == WRITE) && din_vld && !rst);
    ren      = (state == READ) && request && !rst;
    wr_base  = entering ? lut_base : base;
    waddr    = wr_base + (ADDRESS'(row) << SH) + ADDRESS'(col);
    raddr    = base + ADDRESS'(rcnt);
    flen     = nrow << SH;
    row_last = (row == nrow - 13'd1);
    wr_last  = row_last && (col == CW'(NCOL - 1));
    rd_last  = (rcnt == flen - 13'd1);
  end

  // Frame FSM, write/read counters and registered read-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      nrow       <= '0;
      row        <= '0;
      col        <= '0;
      rcnt       <= '0;
      dout_vld   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_vld   <= ren;
      frame_done <= ren && rd_last;
      case (state)
        IDLE: begin
          if (din_vld && lut_ok) begin
            state <= WRITE;
            base  <= lut_base;
            nrow  <= m_len >> SH;
            // first sample lands at row 0 here; every supported nrow exceeds 1
            row   <= 13'd1;
            col   <= '0;
          end
        end
        WRITE: begin
          if (din_vld) begin
            if (wr_last) begin
              state <= READ;
              row   <= '0;
              col   <= '0;
              rcnt  <= '0;
            end else if (row_last) begin
              row <= '0;
              col <= col + CW'(1);
            end else begin
              row <= row + 13'd1;
            end
          end
        end
        READ: begin
          if (request) begin
            if (rd_last) begin
              state <= IDLE;
              rcnt  <= '0;
              base  <= '0;
              nrow  <= '0;
            end else begin
              rcnt <= rcnt + 13'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ASM_DEINT_ERR_EN
  // Sticky error: unsupported length on a start attempt, or input during read
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (((state == IDLE) && din_vld && !lut_ok) ||
                 ((state == READ) && din_vld)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_asm_deint_ctrl.sv
// Self-checking bench for asm_deint_ctrl: expected addresses come from the
// deinterleaver permutation written as plain arithmetic on the sample index.
module tb_asm_deint_ctrl;

  localparam int NCOL    = 8;
  localparam int ADDRESS = 16;
`ifdef ASM_DEINT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               din_vld;
  logic [12:0]        m_len;
  logic               request;
  logic               wen;
  logic [ADDRESS-1:0] waddr;
  logic               ren;
  logic [ADDRESS-1:0] raddr;
  logic               dout_vld;
  logic               frame_done;
  logic               err;

  int errors = 0;
  int checks = 0;
  bit err_exp = 1'b0;

  asm_deint_ctrl #(.NCOL(NCOL), .ADDRESS(ADDRESS)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_vld    (din_vld),
    .m_len      (m_len),
    .request    (request),
    .wen        (wen),
    .waddr      (waddr),
    .ren        (ren),
    .raddr      (raddr),
    .dout_vld   (dout_vld),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic int base_of(input int len);
    case (len)
      952:     return 'h0000;
      288:     return 'h03C0;
      672:     return 'h04E0;
      1056:    return 'h0780;
      default: return 0;
    endcase
  endfunction

  // Apply inputs just after a rising edge, return at the following falling edge
  task automatic drive(input logic d, input logic [12:0] ml, input logic r);
    @(posedge clk);
    #1;
    din_vld = d;
    m_len   = ml;
    request = r;
    @(negedge clk);
  endtask

  // mode: 0 continuous, 1 every other cycle, 2 random (with stray requests)
  task automatic do_write(input int len, input int mode);
    int k = 0;
    int cyc = 0;
    int nrow = len / NCOL;
    int b = base_of(len);
    logic d, r;
    logic [12:0] ml;
    logic [ADDRESS-1:0] e;
    while (k < len && cyc < 20 * len) begin
      case (mode)
        0:       d = 1'b1;
        1:       d = (cyc % 2 == 0);
        default: d = 1'($urandom_range(0, 1));
      endcase
      r  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      ml = (k == 0 || mode != 2) ? 13'(len) : 13'($urandom);
      drive(d, ml, r);
      checks++;
      if (d) begin
        e = ADDRESS'(b + (k % nrow) * NCOL + k / nrow);
        if (wen !== 1'b1 || waddr !== e) begin
          errors++;
          $display("FAIL write len=%0d k=%0d wen=%b waddr=%h expected wen=1 waddr=%h",
                   len, k, wen, waddr, e);
        end
        k++;
      end else if (wen !== 1'b0) begin
        errors++;
        $display("FAIL write_gap len=%0d k=%0d wen=%b expected 0", len, k, wen);
      end
      checks++;
      if (ren !== 1'b0) begin
        errors++;
        $display("FAIL ren_in_write len=%0d k=%0d ren=%b expected 0", len, k, ren);
      end
      cyc++;
    end
    if (k < len) begin
      errors++;
      $display("FAIL write_timeout len=%0d wrote=%0d expected %0d", len, k, len);
    end
  endtask

  // mode: 0 continuous, 1 one-in-three, 2 random; inject drives stray din_vld
  task automatic do_read(input int len, input int mode, input bit inject);
    int k = 0;
    int cyc = 0;
    int b = base_of(len);
    logic d, r, prev_ren, prev_fd;
    logic [ADDRESS-1:0] e;
    prev_ren = 1'b0;
    prev_fd  = 1'b0;
    while (k < len && cyc < 20 * len) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      d = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inject && r && k == len - 1) d = 1'b1;
      if (d && ERR_EN) err_exp = 1'b1;
      drive(d, 13'(len), r);
      checks++;
      if (dout_vld !== prev_ren || frame_done !== prev_fd) begin
        errors++;
        $display("FAIL read_regs len=%0d k=%0d dout_vld=%b frame_done=%b expected %b %b",
                 len, k, dout_vld, frame_done, prev_ren, prev_fd);
      end
      checks++;
      if (wen !== 1'b0) begin
        errors++;
        $display("FAIL wen_in_read len=%0d k=%0d wen=%b expected 0", len, k, wen);
      end
      checks++;
      if (r) begin
        e = ADDRESS'(b + k);
        if (ren !== 1'b1 || raddr !== e) begin
          errors++;
          $display("FAIL read len=%0d k=%0d ren=%b raddr=%h expected ren=1 raddr=%h",
                   len, k, ren, raddr, e);
        end
        prev_fd  = (k == len - 1);
        prev_ren = 1'b1;
        k++;
      end else begin
        if (ren !== 1'b0) begin
          errors++;
          $display("FAIL read_gap len=%0d k=%0d ren=%b expected 0", len, k, ren);
        end
        prev_ren = 1'b0;
        prev_fd  = 1'b0;
      end
      cyc++;
    end
    if (k < len) begin
      errors++;
      $display("FAIL read_timeout len=%0d read=%0d expected %0d", len, k, len);
    end
    // Back in IDLE: final dout_vld/frame_done appear, request is ignored
    drive(1'b0, 13'(len), 1'b1);
    checks++;
    if (dout_vld !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_end len=%0d dout_vld=%b frame_done=%b expected 1 1",
               len, dout_vld, frame_done);
    end
    checks++;
    if (ren !== 1'b0 || wen !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_read len=%0d ren=%b wen=%b expected 0 0", len, ren, wen);
    end
    checks++;
    if (err !== err_exp) begin
      errors++;
      $display("FAIL err_after_read len=%0d err=%b expected %b", len, err, err_exp);
    end
    drive(1'b0, 13'(len), 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    logic [ADDRESS+ADDRESS+5:0] got;
    got = {wen, waddr, ren, raddr, dout_vld, frame_done, err};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s wen=%b waddr=%h ren=%b raddr=%h dout_vld=%b frame_done=%b err=%b expected all 0",
               tag, wen, waddr, ren, raddr, dout_vld, frame_done, err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; din_vld = 1'b0; request = 1'b0; m_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    err_exp = 1'b0;
    check_all_zero("reset");
  endtask

  task automatic test_continuous_288;
    do_write(288, 0);
    do_read(288, 0, 1'b0);
  endtask

  task automatic test_stall_952;
    do_write(952, 1);
    do_read(952, 1, 1'b0);
  endtask

  task automatic test_unsupported;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 13'd500, 1'b1);
      checks++;
      if (wen !== 1'b0 || ren !== 1'b0) begin
        errors++;
        $display("FAIL unsupported i=%0d wen=%b ren=%b expected 0 0", i, wen, ren);
      end
    end
    if (ERR_EN) err_exp = 1'b1;
    drive(1'b0, 13'd500, 1'b0);
    checks++;
    if (err !== err_exp) begin
      errors++;
      $display("FAIL unsupported_err err=%b expected %b", err, err_exp);
    end
  endtask

  task automatic test_reset_midframe;
    logic [ADDRESS-1:0] e;
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 13'd1056, 1'b0);
      e = ADDRESS'(base_of(1056) + (k % 132) * NCOL + k / 132);
      checks++;
      if (wen !== 1'b1 || waddr !== e) begin
        errors++;
        $display("FAIL mid_write k=%0d wen=%b waddr=%h expected wen=1 waddr=%h", k, wen, waddr, e);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1; din_vld = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    err_exp = 1'b0;
    check_all_zero("mid_reset");
    do_write(672, 0);
    do_read(672, 2, 1'b1);
  endtask

  task automatic test_random;
    int lens[4] = '{952, 288, 672, 1056};
    for (int i = 0; i < 4; i++) begin
      int len = lens[$urandom_range(0, 3)];
      do_write(len, 2);
      do_read(len, 2, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_continuous_288;
    test_stall_952;
    test_unsupported;
    test_reset_midframe;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
